// File: rtl/lamp_monitor.sv
// lamp_monitor
//
// Sequence checker for the one-hot traffic-lamp bus (RED=100, GREEN=010,
// YELLOW=001). It synchronises the bus, follows the RED -> GREEN -> YELLOW
// -> RED order, times every phase and latches the first anomaly as a sticky
// fault with a cause code until clear_fault or reset.
//
// Parameters:
//   DWELL_W    width of the dwell counter (must hold MAX_DWELL+1)
//   MIN_DWELL  shortest legal phase, in clocks
//   MAX_DWELL  longest legal phase, in clocks
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high
//   light[2:0]   lamp bus from the cyclic controller (asynchronous to us)
//   clear_fault  one-cycle pulse: drop the fault and re-arm in IDLE
//   phase[1:0]   tracked phase: 0=unknown, 1=RED, 2=GREEN, 3=YELLOW
//   fault        sticky fault flag
//   fault_code   first cause: 0=none, 1=illegal pattern, 2=wrong order,
//                3=short dwell, 4=long dwell
//   dwell_last   length of the last legally completed phase
//   cycle_count  completed full lamp cycles (only with the macro below)
//
// Optional feature macro: LAMP_MONITOR_STATS_EN adds the cycle_count port
// and its counter; without it the port is absent and all else is the same.

module lamp_monitor #(
  parameter int DWELL_W   = 28,
  parameter int MIN_DWELL = 190_000_000,
  parameter int MAX_DWELL = 210_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         light,
  input  logic               clear_fault,
  output logic [1:0]         phase,
  output logic               fault,
  output logic [2:0]         fault_code,
  output logic [DWELL_W-1:0] dwell_last
`ifdef LAMP_MONITOR_STATS_EN
  ,
  output logic [15:0]        cycle_count
`endif
);

  localparam logic [2:0] MON_IDLE   = 3'd0;
  localparam logic [2:0] MON_RED    = 3'd1;
  localparam logic [2:0] MON_GREEN  = 3'd2;
  localparam logic [2:0] MON_YELLOW = 3'd3;
  localparam logic [2:0] MON_FAULT  = 3'd4;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;

  localparam logic [2:0] CODE_NONE    = 3'd0;
  localparam logic [2:0] CODE_ILLEGAL = 3'd1;
  localparam logic [2:0] CODE_ORDER   = 3'd2;
  localparam logic [2:0] CODE_SHORT   = 3'd3;
  localparam logic [2:0] CODE_LONG    = 3'd4;

  localparam logic [DWELL_W-1:0] DWELL_MIN = DWELL_W'(MIN_DWELL);
  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MAX_DWELL);
  localparam logic [DWELL_W-1:0] DWELL_SAT = '1;

  logic [2:0]         sync1_q;
  logic [2:0]         light_s_q;
  logic [2:0]         light_prev_q;
  logic [DWELL_W-1:0] dwell_q,      dwell_d;
  logic [2:0]         state_q,      state_d;
  logic [1:0]         phase_q,      phase_d;
  logic               fault_q,      fault_d;
  logic [2:0]         code_q,       code_d;
  logic [DWELL_W-1:0] dwell_last_q, dwell_last_d;

  logic               light_change;
  logic               light_onehot;
  logic [2:0]         light_state;
  logic [2:0]         succ_light;
  logic [2:0]         succ_state;
  logic [2:0]         cause;

  // Two-flop synchroniser plus one extra stage remembering the previous
  // synchronised value, so a change is seen exactly once per transition.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q      <= 3'b000;
      light_s_q    <= 3'b000;
      light_prev_q <= 3'b000;
    end else begin
      sync1_q      <= light;
      light_s_q    <= sync1_q;
      light_prev_q <= light_s_q;
    end
  end

  assign light_change = (light_s_q != light_prev_q);

  // Decode the synchronised bus: is it a single lamp, and which phase
  // state would it select.
  always_comb begin
    light_onehot = 1'b1;
    light_state  = MON_IDLE;
    case (light_s_q)
      LAMP_RED:    light_state = MON_RED;
      LAMP_GREEN:  light_state = MON_GREEN;
      LAMP_YELLOW: light_state = MON_YELLOW;
      default:     light_onehot = 1'b0;
    endcase
  end

  // The only lamp value (and matching state) that may legally follow the
  // phase currently being tracked.
  always_comb begin
    succ_light = 3'b000;
    succ_state = MON_IDLE;
    case (state_q)
      MON_RED: begin
        succ_light = LAMP_GREEN;
        succ_state = MON_GREEN;
      end
      MON_GREEN: begin
        succ_light = LAMP_YELLOW;
        succ_state = MON_YELLOW;
      end
      MON_YELLOW: begin
        succ_light = LAMP_RED;
        succ_state = MON_RED;
      end
      default: begin
        succ_light = 3'b000;
        succ_state = MON_IDLE;
      end
    endcase
  end

  // Dwell counter: restarts at 1 on the first cycle of a new value and
  // sticks at all-ones rather than wrapping back into the legal range.
  always_comb begin
    if (light_change) begin
      dwell_d = DWELL_W'(1);
    end else if (dwell_q == DWELL_SAT) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + DWELL_W'(1);
    end
  end

  // Monitor state machine. Checks on a change are ordered so that an
  // illegal pattern outranks a wrong order, which outranks a short dwell.
  // The long-dwell check fires on the cycle the counter would step past
  // MAX_DWELL. clear_fault overrides everything, including a fault found
  // on the same edge, and leaves dwell_last untouched.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    dwell_last_d = dwell_last_q;
    cause        = CODE_NONE;

    case (state_q)
      MON_IDLE: begin
        if (light_s_q != 3'b000) begin
          if (light_onehot) begin
            state_d = light_state;
          end else begin
            cause = CODE_ILLEGAL;
          end
        end
      end
      MON_RED, MON_GREEN, MON_YELLOW: begin
        if (light_change) begin
          if (!light_onehot) begin
            cause = CODE_ILLEGAL;
          end else if (light_s_q != succ_light) begin
            cause = CODE_ORDER;
          end else if (dwell_q < DWELL_MIN) begin
            cause = CODE_SHORT;
          end else begin
            state_d      = succ_state;
            dwell_last_d = dwell_q;
          end
        end else if (dwell_q >= DWELL_MAX) begin
          cause = CODE_LONG;
        end
      end
      MON_FAULT: begin
        state_d = MON_FAULT;
      end
      default: begin
        state_d = MON_IDLE;
      end
    endcase

    if (cause != CODE_NONE) begin
      state_d = MON_FAULT;
      code_d  = cause;
    end

    if (clear_fault) begin
      state_d      = MON_IDLE;
      code_d       = CODE_NONE;
      dwell_last_d = dwell_last_q;
    end
  end

  // Outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_comb begin
    fault_d = (state_d == MON_FAULT);
    case (state_d)
      MON_RED:    phase_d = 2'd1;
      MON_GREEN:  phase_d = 2'd2;
      MON_YELLOW: phase_d = 2'd3;
      default:    phase_d = 2'd0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dwell_q      <= '0;
      state_q      <= MON_IDLE;
      phase_q      <= 2'd0;
      fault_q      <= 1'b0;
      code_q       <= CODE_NONE;
      dwell_last_q <= '0;
    end else begin
      dwell_q      <= dwell_d;
      state_q      <= state_d;
      phase_q      <= phase_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
      dwell_last_q <= dwell_last_d;
    end
  end

  assign phase      = phase_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign dwell_last = dwell_last_q;

`ifdef LAMP_MONITOR_STATS_EN
  logic [15:0] cycle_q, cycle_d;

  // A YELLOW -> RED step in the next state can only come from a legal
  // transition (clear and faults both leave for other states), so it marks
  // one completed cycle. Only reset clears this counter.
  always_comb begin
    if (state_q == MON_YELLOW && state_d == MON_RED) begin
      cycle_d = cycle_q + 16'd1;
    end else begin
      cycle_d = cycle_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_q <= 16'd0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle_count = cycle_q;
`endif

endmodule

// File: tb/tb_lamp_monitor.sv
// tb_lamp_monitor
//
// Self-checking bench for lamp_monitor with MIN_DWELL=4, MAX_DWELL=8 and a
// 4-bit dwell counter. Directed scenarios are followed by a randomized run;
// every cycle is compared against a behavioural model that sees the lamp
// bus through a two-sample delay queue and applies the phase rules with
// plain integer arithmetic.

module tb_lamp_monitor;

  localparam int TW   = 4;
  localparam int TMIN = 4;
  localparam int TMAX = 8;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] GRN = 3'b010;
  localparam logic [2:0] YEL = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    light = 3'b000;
  logic          clear_fault = 1'b0;
  logic [1:0]    phase;
  logic          fault;
  logic [2:0]    fault_code;
  logic [TW-1:0] dwell_last;
`ifdef LAMP_MONITOR_STATS_EN
  logic [15:0]   cycle_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [2:0] m_sync[$];
  logic [2:0] m_last;
  int         m_held;
  int         m_phase;
  bit         m_fault;
  int         m_code;
  int         m_dlast;
  int         m_cycles;

  lamp_monitor #(
    .DWELL_W   (TW),
    .MIN_DWELL (TMIN),
    .MAX_DWELL (TMAX)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .light       (light),
    .clear_fault (clear_fault),
    .phase       (phase),
    .fault       (fault),
    .fault_code  (fault_code),
    .dwell_last  (dwell_last)
`ifdef LAMP_MONITOR_STATS_EN
   ,.cycle_count (cycle_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic int lampIdx(input logic [2:0] v);
    case (v)
      RED:     return 1;
      GRN:     return 2;
      YEL:     return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] nextLamp(input logic [2:0] v);
    if (v == RED) return GRN;
    if (v == GRN) return YEL;
    return RED;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_sync   = {OFF, OFF};
    m_last   = OFF;
    m_held   = 0;
    m_phase  = 0;
    m_fault  = 1'b0;
    m_code   = 0;
    m_dlast  = 0;
    m_cycles = 0;
  endtask

  task automatic modelRaise(input int code);
    m_fault = 1'b1;
    m_code  = code;
    m_phase = 0;
  endtask

  // One clock edge of the reference: v/c are what the DUT sampled there.
  task automatic modelStep(input logic [2:0] v, input logic c);
    logic [2:0] ls;
    bit         chg;
    int         h;
    int         idx;
    m_sync.push_back(v);
    ls  = m_sync.pop_front();
    chg = (ls != m_last);
    h   = m_held;
    idx = lampIdx(ls);
    if (c) begin
      m_fault = 1'b0;
      m_code  = 0;
      m_phase = 0;
    end else if (!m_fault) begin
      if (m_phase == 0) begin
        if (ls != OFF) begin
          if (idx != 0) m_phase = idx;
          else          modelRaise(1);
        end
      end else if (chg) begin
        if (idx == 0)                     modelRaise(1);
        else if (idx != m_phase % 3 + 1)  modelRaise(2);
        else if (h < TMIN)                modelRaise(3);
        else begin
          m_dlast = h;
          if (m_phase == 3) m_cycles = (m_cycles + 1) % 65536;
          m_phase = idx;
        end
      end else if (h + 1 > TMAX) begin
        modelRaise(4);
      end
    end
    if (chg) m_held = 1;
    else     m_held = (h + 1 > (1 << TW) - 1) ? (1 << TW) - 1 : h + 1;
    m_last = ls;
  endtask

  task automatic checkOutput();
    checkVal("phase",      32'(phase),      m_phase);
    checkVal("fault",      32'(fault),      32'(m_fault));
    checkVal("fault_code", 32'(fault_code), m_code);
    checkVal("dwell_last", 32'(dwell_last), m_dlast);
`ifdef LAMP_MONITOR_STATS_EN
    checkVal("cycle_count", 32'(cycle_count), m_cycles);
`endif
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic c, input int n);
    for (int i = 0; i < n; i++) begin
      light       = v;
      clear_fault = c;
      @(posedge clock);
      modelStep(v, c);
      #1;
      checkOutput();
    end
    clear_fault = 1'b0;
  endtask

  // Asserts reset between edges, checks the outputs drop at once, then
  // releases it away from the clock edge.
  task automatic doReset();
    reset       = 1'b1;
    light       = OFF;
    clear_fault = 1'b0;
    #1;
    modelReset();
    checkOutput();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] cur;
    logic [2:0] v;
    int         len;

    #2;
    $display("[TB] reset state");
    doReset();

    $display("[TB] legal cycle");
    applyStimulus(RED, 0, 5);
    applyStimulus(GRN, 0, 3);
    checkVal("legal_phase_green", 32'(phase), 2);
    checkVal("legal_dwell_red", 32'(dwell_last), 5);
    applyStimulus(GRN, 0, 3);
    applyStimulus(YEL, 0, 3);
    checkVal("legal_phase_yellow", 32'(phase), 3);
    checkVal("legal_dwell_green", 32'(dwell_last), 6);
    applyStimulus(YEL, 0, 1);
    applyStimulus(RED, 0, 3);
    checkVal("legal_phase_red", 32'(phase), 1);
    checkVal("legal_dwell_yellow", 32'(dwell_last), 4);
    checkVal("legal_fault", 32'(fault), 0);
`ifdef LAMP_MONITOR_STATS_EN
    checkVal("legal_cycles", 32'(cycle_count), 1);
`endif

    $display("[TB] max dwell boundary");
    doReset();
    applyStimulus(RED, 0, 8);
    applyStimulus(GRN, 0, 3);
    checkVal("max8_fault", 32'(fault), 0);
    checkVal("max8_dwell", 32'(dwell_last), 8);
    doReset();
    applyStimulus(RED, 0, 9);
    applyStimulus(GRN, 0, 2);
    checkVal("max9_code", 32'(fault_code), 4);

    $display("[TB] wrong order");
    doReset();
    applyStimulus(RED, 0, 5);
    applyStimulus(YEL, 0, 3);
    checkVal("order_fault", 32'(fault), 1);
    checkVal("order_code", 32'(fault_code), 2);
    checkVal("order_phase", 32'(phase), 0);

    $display("[TB] short dwell");
    doReset();
    applyStimulus(RED, 0, 5);
    applyStimulus(GRN, 0, 2);
    applyStimulus(YEL, 0, 3);
    checkVal("short_code", 32'(fault_code), 3);
    checkVal("short_dwell_frozen", 32'(dwell_last), 5);

    $display("[TB] long dwell and clear");
    doReset();
    applyStimulus(RED, 0, 5);
    applyStimulus(GRN, 0, 12);
    checkVal("long_code", 32'(fault_code), 4);
    applyStimulus(GRN, 1, 1);
    checkVal("clear_fault_low", 32'(fault), 0);
    checkVal("clear_phase_idle", 32'(phase), 0);
    applyStimulus(GRN, 0, 1);
    checkVal("clear_reenter_green", 32'(phase), 2);
    applyStimulus(OFF, 0, 3);

    $display("[TB] illegal pattern priority");
    doReset();
    applyStimulus(RED, 0, 2);
    applyStimulus(3'b110, 0, 1);
    applyStimulus(GRN, 0, 2);
    applyStimulus(OFF, 0, 3);
    checkVal("illegal_code", 32'(fault_code), 1);
    doReset();
    applyStimulus(3'b011, 0, 3);
    checkVal("idle_multibit_code", 32'(fault_code), 1);

    $display("[TB] reset mid-yellow");
    doReset();
    applyStimulus(RED, 0, 5);
    applyStimulus(GRN, 0, 5);
    applyStimulus(YEL, 0, 3);
    checkVal("pre_reset_phase", 32'(phase), 3);
    #2;
    doReset();
    checkVal("reset_dwell_last", 32'(dwell_last), 0);

    $display("[TB] clear/fault collision");
    applyStimulus(RED, 0, 5);
    applyStimulus(GRN, 0, 2);
    applyStimulus(YEL, 0, 2);
    applyStimulus(YEL, 1, 1);
    checkVal("collide_fault", 32'(fault), 0);
    checkVal("collide_code", 32'(fault_code), 0);
    applyStimulus(YEL, 0, 1);
    checkVal("collide_reenter", 32'(phase), 3);

    $display("[TB] randomized run");
    doReset();
    cur = RED;
    for (int s = 0; s < 160; s++) begin
      if ($urandom_range(0, 99) < 8) begin
        v = 3'($urandom_range(0, 7));
      end else begin
        v   = cur;
        cur = nextLamp(cur);
      end
      if ($urandom_range(0, 99) < 70) len = $urandom_range(TMIN, TMAX);
      else                             len = $urandom_range(1, 12);
      applyStimulus(v, 0, len);
      if ($urandom_range(0, 99) < 10) applyStimulus(v, 1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lamp_monitor.md
# lamp_monitor

Sequence checker for the 3-bit one-hot traffic-lamp bus driven by the board's cyclic lamp controller. It samples `light`, tracks the expected RED → GREEN → YELLOW → RED order, and measures how long each phase is held. It raises a sticky fault with a cause code on an illegal pattern, a wrong transition order, a phase that is too short, or a phase that is too long. The block sits beside the controller on the Nexys A7 top level and drives LEDs and debug outputs.

## Interface
- `DWELL_W`, 28: width of the dwell counter; must hold `MAX_DWELL`+1.
- `MIN_DWELL`, 190_000_000: minimum legal phase length, in clocks.
- `MAX_DWELL`, 210_000_000: maximum legal phase length, in clocks.
- `clock` input 1: system clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `light` input 3: lamp bus; RED=3'b100, GREEN=3'b010, YELLOW=3'b001.
- `clear_fault` input 1: single-cycle pulse that clears the fault and re-arms the monitor.
- `phase` output 2: tracked phase; 0=unknown, 1=RED, 2=GREEN, 3=YELLOW.
- `fault` output 1: sticky fault flag.
- `fault_code` output 3: cause of the first fault; 0=none, 1=illegal pattern, 2=wrong order, 3=short dwell, 4=long dwell.
- `dwell_last` output DWELL_W: length of the last legally completed phase.
- `cycle_count` output 16: completed full lamp cycles; present only with `LAMP_MONITOR_STATS_EN`.

## Operation
- **Input synchroniser.** `light` passes through a 2-flop synchroniser; the second stage is `light_s`. Both stages reset to 0.
- **States.** MON_IDLE, MON_RED, MON_GREEN, MON_YELLOW, MON_FAULT.
- **Reset values.** State = MON_IDLE. `phase`=0, `fault`=0, `fault_code`=0, `dwell_last`=0, `cycle_count`=0, dwell counter = 0.
- **Dwell counter.**
  - Loads 1 on every cycle where `light_s` differs from its previous value.
  - Otherwise increments, saturating at all-ones.
- **MON_IDLE.**
  - `light_s`=000: stay in IDLE, no fault.
  - Valid one-hot value: enter the matching phase state.
  - Multi-bit value: go to FAULT with code 1.
- **Phase states, on a `light_s` change.** Checks are applied in priority order; the first that matches decides the outcome:
  1. New value is not one-hot (including 000): code 1.
  2. New value is not the successor of the current phase: code 2.
  3. Previous dwell < `MIN_DWELL`: code 3.
  4. Otherwise the transition is legal: advance to the next phase and load `dwell_last` with the previous dwell.
- **Phase states, no change.** If the dwell counter exceeds `MAX_DWELL` (held `MAX_DWELL`+1 cycles), go to FAULT with code 4.
- **MON_FAULT.**
  - `fault`=1 and `phase`=0.
  - `fault_code` holds the first cause; later anomalies are ignored.
  - `dwell_last` is frozen.
- **`clear_fault`.**
  - In any state: go to MON_IDLE, `fault`=0, `fault_code`=0. `dwell_last` is kept.
  - If asserted in the same cycle a fault is detected, clear wins and the monitor goes to MON_IDLE.
- **Reset mid-phase.** All state is dropped immediately (asynchronous); the monitor re-arms in IDLE.

## Timing
- A `light` value sampled at edge N appears on `light_s` after edge N+1.
- `phase`, `fault`, `fault_code`, `dwell_last` and `cycle_count` update at edge N+2. All outputs are registered.
- The long-dwell fault asserts at the edge on which the counter would pass `MAX_DWELL`.
- `clear_fault` sampled at edge N: `fault`=0 and `phase`=0 after edge N.
- No handshakes; `light` may change on any cycle.

## Configuration
- **`LAMP_MONITOR_STATS_EN` defined.**
  - `cycle_count` port and counter are present.
  - The counter increments on each legal YELLOW → RED transition and wraps from 16'hFFFF to 0.
  - Cleared only by `reset`; `clear_fault` does not clear it.
- **Not defined.** The port and counter are absent; all other behaviour is identical.

## Test plan
All scenarios use `MIN_DWELL`=4, `MAX_DWELL`=8.
- **Legal cycle.** After reset, drive RED 5, GREEN 6, YELLOW 4, RED 3 clocks.
  - Expect `fault`=0 throughout, with `phase` sequencing 1 → 2 → 3 → 1.
  - Expect `dwell_last` = 5, 6, 4 after each change.
  - With the macro: `cycle_count`=1.
- **Wrong order.** RED 5 clocks, then YELLOW.
  - Expect `fault`=1 and `fault_code`=2 two edges after YELLOW is sampled; `phase`=0.
- **Short dwell.** RED 5, then GREEN for 2 clocks, then YELLOW.
  - Expect `fault_code`=3 and `dwell_last`=5 (frozen).
- **Long dwell and clear.** Hold GREEN (entered via RED 5) for 12 clocks.
  - Expect `fault_code`=4 when the 9th held cycle is reached.
  - Then pulse `clear_fault` while GREEN is still driven: `fault`=0, monitor re-enters IDLE, then GREEN with `phase`=2.
- **Illegal pattern and priority.** From RED, drive 3'b110; then 3'b010 for 2 clocks.
  - Expect `fault_code`=1, not 2 or 3.
  - The later short GREEN does not overwrite the code.
- **Reset and clear/fault collision.** Assert `reset` mid-YELLOW.
  - Expect all outputs 0 immediately.
  - Separately, assert `clear_fault` on the same edge a short-dwell violation is detected: expect `fault`=0 and the monitor in IDLE.
